// File: rtl/mem_ctrl_pkg.sv
// mem_ctrl_pkg: access-length/state encodings, IO region tag, latched transaction record and length decode
package mem_ctrl_pkg;
  localparam logic [1:0] MEM_LEN_BYTE = 2'd0;
  localparam logic [1:0] MEM_LEN_HALF = 2'd1;
  localparam logic [1:0] MEM_LEN_WORD = 2'd2;
  localparam logic [1:0] MC_IDLE = 2'd0;
  localparam logic [1:0] MC_READ = 2'd1;
  localparam logic [1:0] MC_WRITE = 2'd2;
  localparam logic [1:0] IO_HI_DEF = 2'b11;
  typedef struct packed {
    logic [31:0] base;
    logic [31:0] wdata;
    logic lsb;
    logic wr;
    logic [2:0] n;
  } txn_t;
  function automatic logic [2:0] len_to_n(input logic [1:0] len);
    return len == MEM_LEN_BYTE ? 3'd1 : len == MEM_LEN_HALF ? 3'd2 : 3'd4;
  endfunction
endpackage

// File: rtl/mem_ctrl_if.sv
// mem_ctrl_if: IF/LSB request-response, flush, IO back-pressure and RAM byte-port signals
interface mem_ctrl_if;
  logic if_req;
  logic [31:0] if_addr;
  logic [31:0] if_data;
  logic if_done;
  logic lsb_req;
  logic lsb_wr;
  logic [1:0] lsb_len;
  logic [31:0] lsb_addr;
  logic [31:0] lsb_wdata;
  logic [31:0] lsb_rdata;
  logic lsb_done;
  logic flush;
  logic [7:0] mem_din;
  logic [7:0] mem_dout;
  logic [31:0] mem_a;
  logic mem_wr;
  logic io_buffer_full;
  modport master (
    output if_req, if_addr, lsb_req, lsb_wr, lsb_len, lsb_addr, lsb_wdata, flush, mem_din, io_buffer_full,
    input if_data, if_done, lsb_rdata, lsb_done, mem_dout, mem_a, mem_wr
  );
  modport slave (
    input if_req, if_addr, lsb_req, lsb_wr, lsb_len, lsb_addr, lsb_wdata, flush, mem_din, io_buffer_full,
    output if_data, if_done, lsb_rdata, lsb_done, mem_dout, mem_a, mem_wr
  );
endinterface

// File: rtl/mem_rr_arbiter.sv
// mem_rr_arbiter: two-way round-robin, grant[0]=IF grant[1]=LSB, tie goes to the side not granted last
module mem_rr_arbiter (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       if_req,
  input  logic       lsb_req,
  output logic [1:0] grant
);
  logic last_grant;
  always_comb begin
    grant = !en ? 2'b00 : if_req && lsb_req ? (last_grant ? 2'b01 : 2'b10) : {lsb_req, if_req};
  end
  always_ff @(posedge clk) begin
    if (rst) last_grant <= 1'b0;
    else if (|grant) last_grant <= grant[1];
  end
endmodule

// File: rtl/mem_ctrl.sv
// mem_ctrl: arbitrates IF/LSB onto the byte-wide RAM/IO port, sequencing 1/2/4-byte little-endian accesses
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter logic [1:0] IO_HI = IO_HI_DEF
) (
  input logic       clk,
  input logic       rst,
  input logic       rdy,
  mem_ctrl_if.slave bus
);
  logic [1:0] state, grant, lane;
  logic [2:0] c, nx;
  logic [31:0] rbuf, rword, a_q;
  logic [7:0] d_q, wb;
  logic wr_q, stall, en;
  txn_t t;
  assign en = rdy && state == MC_IDLE && !bus.if_done && !bus.lsb_done && !bus.flush;
  mem_rr_arbiter u_arb (
    .clk(clk),
    .rst(rst),
    .en(en),
    .if_req(bus.if_req),
    .lsb_req(bus.lsb_req),
    .grant(grant)
  );
  assign nx = c + 3'd1;
  assign lane = 2'(c - 3'd1);
  assign wb = 8'(t.wdata >> {nx[1:0], 3'b000});
  assign rword = rbuf | ({24'b0, bus.mem_din} << {lane, 3'b000});
  assign stall = state == MC_WRITE && t.wr && bus.io_buffer_full && t.base[17:16] == IO_HI;
  assign bus.mem_wr = wr_q && rdy && !stall;
  assign bus.mem_dout = d_q;
  // While frozen, point the RAM at the byte due for capture so mem_din is valid again on resume.
  assign bus.mem_a = !rdy && state == MC_READ && c != 3'd0 ? t.base + 32'(c) - 32'd1 : a_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= MC_IDLE;
      c <= '0;
      t <= '0;
      rbuf <= '0;
      a_q <= '0;
      d_q <= '0;
      wr_q <= 1'b0;
      bus.if_data <= '0;
      bus.if_done <= 1'b0;
      bus.lsb_rdata <= '0;
      bus.lsb_done <= 1'b0;
    end else if (rdy && !stall) begin
      bus.if_done <= 1'b0;
      bus.lsb_done <= 1'b0;
      case (state)
        MC_IDLE: if (|grant) begin
          t <= grant[1] ? txn_t'{bus.lsb_addr, bus.lsb_wdata, 1'b1, bus.lsb_wr, len_to_n(bus.lsb_len)}
                        : txn_t'{bus.if_addr, 32'd0, 1'b0, 1'b0, 3'd4};
          state <= grant[1] && bus.lsb_wr ? MC_WRITE : MC_READ;
          c <= '0;
          rbuf <= '0;
          a_q <= grant[1] ? bus.lsb_addr : bus.if_addr;
          d_q <= bus.lsb_wdata[7:0];
          wr_q <= grant[1] && bus.lsb_wr;
        end
        MC_READ: if (bus.flush) state <= MC_IDLE;
        else begin
          c <= nx;
          if (nx < t.n) a_q <= t.base + 32'(nx);
          if (c != 3'd0) rbuf <= rword;
          if (c == t.n) begin
            state <= MC_IDLE;
            if (t.lsb) begin
              bus.lsb_rdata <= rword;
              bus.lsb_done <= 1'b1;
            end else begin
              bus.if_data <= rword;
              bus.if_done <= 1'b1;
            end
          end
        end
        MC_WRITE: if (nx < t.n) begin
          c <= nx;
          a_q <= t.base + 32'(nx);
          d_q <= wb;
        end else begin
          wr_q <= 1'b0;
          bus.lsb_done <= 1'b1;
          state <= MC_IDLE;
        end
        default: state <= MC_IDLE;
      endcase
    end
  end
endmodule
